// File: rtl/rv_multicycle_ctrl_pkg.sv
// rv_ctrl_pkg
//   Shared constants and types for the RV32I-subset multi-cycle controller:
//   opcode/funct encodings, ALU and immediate-format select encodings,
//   the instruction class enum, the FSM state enum and the control-word struct.
//   Build option: ILLEGAL_TRAP_EN adds the ST_TRAP state.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_R  = 7'b0110011;
  localparam logic [6:0] OPC_I  = 7'b0010011;
  localparam logic [6:0] OPC_LW = 7'b0000011;
  localparam logic [6:0] OPC_SW = 7'b0100011;
  localparam logic [6:0] OPC_BR = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_ADD = 7'h00;
  localparam logic [6:0] F7_SUB = 7'h20;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ
  } instr_cls_e;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB
`ifdef ILLEGAL_TRAP_EN
    , ST_TRAP
`endif
  } state_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       addr_src;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src_br;
    logic [1:0] alu_sel;
    logic       alu_src_imm;
    logic [1:0] imm_sel;
    logic       reg_we;
    logic       wb_src;
    logic       bus_err;
    logic       illegal;
  } ctrl_t;

  // Immediate format needed by each instruction class (R-type ignores it).
  function automatic logic [1:0] imm_sel_of(instr_cls_e cls);
    case (cls)
      CLS_SW:  return IMM_S;
      CLS_BEQ: return IMM_B;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// rv_multicycle_ctrl_if
//   Bundle between the controller and the datapath / memory port.
//   master: the controller (drives all control outputs, reads ir/mem_ack/alu_zero).
//   slave : the datapath side (drives ir/mem_ack/alu_zero, reads controls).
interface rv_multicycle_ctrl_if;
  logic [31:0] ir;
  logic        mem_ack;
  logic        alu_zero;
  logic        mem_req;
  logic        mem_we;
  logic        addr_src;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src_br;
  logic [1:0]  alu_sel;
  logic        alu_src_imm;
  logic [1:0]  imm_sel;
  logic        reg_we;
  logic        wb_src;
  logic        bus_err;
  logic        illegal;

  modport master (
    input  ir, mem_ack, alu_zero,
    output mem_req, mem_we, addr_src, ir_we, pc_we, pc_src_br,
           alu_sel, alu_src_imm, imm_sel, reg_we, wb_src, bus_err, illegal
  );

  modport slave (
    output ir, mem_ack, alu_zero,
    input  mem_req, mem_we, addr_src, ir_we, pc_we, pc_src_br,
           alu_sel, alu_src_imm, imm_sel, reg_we, wb_src, bus_err, illegal
  );
endinterface

// File: rtl/rv_multicycle_ctrl_alu_dec.sv
// rv_alu_dec
//   Combinational instruction decoder: opcode/funct3/funct7 -> ALU op,
//   instruction class and legality for ADD SUB AND OR ADDI ANDI ORI LW SW BEQ.
//   Ports: opcode, funct3, funct7 (in); alu_sel, cls, legal (out).
module rv_alu_dec
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [1:0] alu_sel,
  output instr_cls_e cls,
  output logic       legal
);

  always_comb begin
    alu_sel = ALU_ADD;
    cls     = CLS_R;
    legal   = 1'b0;
    case (opcode)
      OPC_R: begin
        cls = CLS_R;
        case (funct3)
          F3_ADD: begin
            if (funct7 == F7_ADD) begin
              legal   = 1'b1;
              alu_sel = ALU_ADD;
            end else if (funct7 == F7_SUB) begin
              legal   = 1'b1;
              alu_sel = ALU_SUB;
            end
          end
          F3_AND: begin
            legal   = 1'b1;
            alu_sel = ALU_AND;
          end
          F3_OR: begin
            legal   = 1'b1;
            alu_sel = ALU_OR;
          end
          default: ;
        endcase
      end
      OPC_I: begin
        cls = CLS_I;
        case (funct3)
          F3_ADD: begin
            legal   = 1'b1;
            alu_sel = ALU_ADD;
          end
          F3_AND: begin
            legal   = 1'b1;
            alu_sel = ALU_AND;
          end
          F3_OR: begin
            legal   = 1'b1;
            alu_sel = ALU_OR;
          end
          default: ;
        endcase
      end
      OPC_LW: begin
        cls   = CLS_LW;
        legal = (funct3 == F3_W);
      end
      OPC_SW: begin
        cls   = CLS_SW;
        legal = (funct3 == F3_W);
      end
      OPC_BR: begin
        cls     = CLS_BEQ;
        alu_sel = ALU_SUB;
        legal   = (funct3 == F3_BEQ);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
//   Multi-cycle control FSM for the RV32I-subset core. Sequences
//   fetch/decode/execute/memory/writeback and drives the ALU and datapath muxes.
//   Ports: clk, rst (async, active-high); bus (rv_multicycle_ctrl_if.master).
//   Parameter ACK_TIMEOUT: cycles a memory request may wait for ack (0 = no limit).
//   Build option: ILLEGAL_TRAP_EN -- illegal instructions lock the FSM in TRAP
//   until reset; without it they retire as a 2-cycle NOP and illegal stays 0.
//
//   state  | meaning
//   FETCH  | instruction read at PC; on ack load IR and step PC by 4
//   DECODE | one idle cycle while IR settles through the decoder
//   EXEC   | ALU op for the class; BEQ resolves the branch here
//   MEM    | data read/write at ALU result
//   WB     | register-file write from ALU or memory
//   TRAP   | illegal instruction seen; frozen until reset
//
//   Outputs are decoded combinationally from state, IR and mem_ack so the
//   fetch/memory handshake can complete in the same cycle as the ack.
module rv_multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rv_multicycle_ctrl_if.master  bus
);

  localparam bit         TIMEOUT_EN = (ACK_TIMEOUT > 0);
  localparam logic [7:0] WAIT_LAST  = TIMEOUT_EN ? 8'(ACK_TIMEOUT - 1) : 8'd0;

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic [1:0] dec_alu_sel;
  instr_cls_e dec_cls;
  logic       dec_legal;
  ctrl_t      ctrl;

  rv_alu_dec u_dec (
    .opcode  (bus.ir[6:0]),
    .funct3  (bus.ir[14:12]),
    .funct7  (bus.ir[31:25]),
    .alu_sel (dec_alu_sel),
    .cls     (dec_cls),
    .legal   (dec_legal)
  );

  always_comb begin
    ctrl       = '0;
    state_d    = state_q;
    wait_cnt_d = '0;

    case (state_q)
      ST_FETCH: begin
        ctrl.mem_req = 1'b1;
        if (bus.mem_ack) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (dec_legal) begin
          state_d = ST_EXEC;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = ST_TRAP;
`else
          state_d = ST_FETCH;
`endif
        end
      end

      ST_EXEC: begin
        ctrl.alu_sel     = dec_alu_sel;
        ctrl.alu_src_imm = (dec_cls != CLS_R) && (dec_cls != CLS_BEQ);
        ctrl.imm_sel     = imm_sel_of(dec_cls);
        case (dec_cls)
          CLS_LW, CLS_SW: state_d = ST_MEM;
          CLS_BEQ: begin
            ctrl.pc_we     = bus.alu_zero;
            ctrl.pc_src_br = bus.alu_zero;
            state_d        = ST_FETCH;
          end
          default: state_d = ST_WB;
        endcase
      end

      ST_MEM: begin
        // The address comes straight from the ALU, so its controls are held.
        ctrl.alu_sel     = dec_alu_sel;
        ctrl.alu_src_imm = 1'b1;
        ctrl.imm_sel     = imm_sel_of(dec_cls);
        ctrl.mem_req     = 1'b1;
        ctrl.addr_src    = 1'b1;
        ctrl.mem_we      = (dec_cls == CLS_SW);
        if (bus.mem_ack) begin
          state_d = (dec_cls == CLS_LW) ? ST_WB : ST_FETCH;
        end
      end

      ST_WB: begin
        // ALU result is written unregistered, so the EXEC controls are held.
        ctrl.alu_sel     = dec_alu_sel;
        ctrl.alu_src_imm = (dec_cls != CLS_R);
        ctrl.imm_sel     = imm_sel_of(dec_cls);
        ctrl.reg_we      = 1'b1;
        ctrl.wb_src      = (dec_cls == CLS_LW);
        state_d          = ST_FETCH;
      end

`ifdef ILLEGAL_TRAP_EN
      ST_TRAP: begin
        ctrl.illegal = 1'b1;
        state_d      = ST_TRAP;
      end
`endif

      default: state_d = ST_FETCH;
    endcase

    // Shared wait/timeout for FETCH and MEM. Any state change (or the timeout
    // itself) leaves the counter at zero, so it restarts on every entry.
    if (ctrl.mem_req && !bus.mem_ack) begin
      if (TIMEOUT_EN && (wait_cnt_q == WAIT_LAST)) begin
        ctrl.bus_err = 1'b1;
        state_d      = ST_FETCH;
      end else begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end

    if (rst) begin
      ctrl = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign bus.mem_req     = ctrl.mem_req;
  assign bus.mem_we      = ctrl.mem_we;
  assign bus.addr_src    = ctrl.addr_src;
  assign bus.ir_we       = ctrl.ir_we;
  assign bus.pc_we       = ctrl.pc_we;
  assign bus.pc_src_br   = ctrl.pc_src_br;
  assign bus.alu_sel     = ctrl.alu_sel;
  assign bus.alu_src_imm = ctrl.alu_src_imm;
  assign bus.imm_sel     = ctrl.imm_sel;
  assign bus.reg_we      = ctrl.reg_we;
  assign bus.wb_src      = ctrl.wb_src;
  assign bus.bus_err     = ctrl.bus_err;
  assign bus.illegal     = ctrl.illegal;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
`timescale 1ns/1ps
module tb_rv_multicycle_ctrl;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  rv_multicycle_ctrl_if bus ();

  rv_multicycle_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  // Observed control word, bit positions chosen by the bench.
  localparam logic [14:0] O_MREQ = 15'h0001, O_MWE = 15'h0002, O_ADDR = 15'h0004,
                          O_IRWE = 15'h0008, O_PCWE = 15'h0010, O_BR = 15'h0020,
                          O_IMM  = 15'h0100, O_RWE = 15'h0800, O_WBM = 15'h1000,
                          O_BERR = 15'h2000, O_ILL = 15'h4000;
  localparam logic [14:0] M_SIDE = 15'h683F, M_SEL = 15'h00C0, M_SRC = 15'h0100,
                          M_IMMSEL = 15'h0600, M_ALL = 15'h7FFF;

  logic [14:0] obs;
  assign obs = {bus.illegal, bus.bus_err, bus.wb_src, bus.reg_we, bus.imm_sel,
                bus.alu_src_imm, bus.alu_sel, bus.pc_src_br, bus.pc_we, bus.ir_we,
                bus.addr_src, bus.mem_we, bus.mem_req};

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] ir_cur = 32'h0;

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_ADDI, K_ANDI, K_ORI,
                K_LW, K_SW, K_BEQ, K_ILL} kind_e;

  task automatic check(input string tag, input logic [14:0] got, input logic [14:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, sample 1ns later.
  task automatic step(input string tag, input logic ack, input logic zero,
                      input logic [14:0] want, input logic [14:0] mask);
    @(negedge clk);
    bus.ir       = ir_cur;
    bus.mem_ack  = ack;
    bus.alu_zero = zero;
    #1 check(tag, obs & mask, want & mask);
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [14:0] sel_f(int op);
    return 15'(op) << 6;
  endfunction

  function automatic logic [14:0] immsel_f(int v);
    return 15'(v) << 9;
  endfunction

  // ISA table lookup.
  function automatic kind_e classify(logic [31:0] i);
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    f7 = i[31:25];
    case (op)
      7'h33: begin
        if (f3 == 3'd0 && f7 == 7'h00) return K_ADD;
        if (f3 == 3'd0 && f7 == 7'h20) return K_SUB;
        if (f3 == 3'd7) return K_AND;
        if (f3 == 3'd6) return K_OR;
      end
      7'h13: begin
        if (f3 == 3'd0) return K_ADDI;
        if (f3 == 3'd7) return K_ANDI;
        if (f3 == 3'd6) return K_ORI;
      end
      7'h03: if (f3 == 3'd2) return K_LW;
      7'h23: if (f3 == 3'd2) return K_SW;
      7'h63: if (f3 == 3'd0) return K_BEQ;
      default: ;
    endcase
    return K_ILL;
  endfunction

  function automatic int alu_op(kind_e k);
    case (k)
      K_SUB, K_BEQ:  return 1;
      K_AND, K_ANDI: return 2;
      K_OR,  K_ORI:  return 3;
      default:       return 0;
    endcase
  endfunction

  // Random instruction word: random register/immediate fields, fixed opcode fields.
  function automatic logic [31:0] make_ir(int sel);
    logic [31:0] w;
    w = $urandom;
    case (sel)
      0: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h00; end
      1: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h20; end
      2: begin w[6:0] = 7'h33; w[14:12] = 3'd7; end
      3: begin w[6:0] = 7'h33; w[14:12] = 3'd6; end
      4: begin w[6:0] = 7'h13; w[14:12] = 3'd0; end
      5: begin w[6:0] = 7'h13; w[14:12] = 3'd7; end
      6: begin w[6:0] = 7'h13; w[14:12] = 3'd6; end
      7: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
      8: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
      9: begin w[6:0] = 7'h63; w[14:12] = 3'd0; end
      10: begin w[6:0] = 7'h33; w[14:12] = 3'd0; w[31:25] = 7'h01; end
      default: ;
    endcase
    return w;
  endfunction

  // Memory handshake: `waits` cycles without ack, then the ack cycle, unless
  // the timeout fires first (bus_err on the TO-th waiting cycle).
  task automatic mem_phase(input string tag, input int waits, input logic [14:0] base,
                           input logic [14:0] on_ack, output bit acked);
    acked = 1'b0;
    for (int k = 0; k < waits; k++) begin
      if (k == TO - 1) begin
        step({tag, "_TIMEOUT"}, 1'b0, rnd_bit(), base | O_BERR, M_SIDE);
        return;
      end
      step({tag, "_WAIT"}, 1'b0, rnd_bit(), base, M_SIDE);
    end
    step({tag, "_ACK"}, 1'b1, rnd_bit(), on_ack, M_SIDE);
    acked = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    bus.mem_ack = 1'b1;
    #1 check("RST", obs, 15'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  task automatic run_instr(input logic [31:0] ir, input int wf, input int wm, input logic zero);
    kind_e       k;
    bit          acked;
    int          left;
    logic [14:0] ex, mk;
    k      = classify(ir);
    ir_cur = ir;
    left   = wf;
    do begin
      mem_phase("FETCH", left, O_MREQ, O_MREQ | O_IRWE | O_PCWE, acked);
      left -= TO;
    end while (!acked);

    step("DECODE", rnd_bit(), rnd_bit(), 15'h0, M_SIDE);
    if (k == K_ILL) begin
`ifdef ILLEGAL_TRAP_EN
      repeat (3) step("TRAP", rnd_bit(), rnd_bit(), O_ILL, M_ALL);
      do_reset();
`endif
      return;
    end

    case (k)
      K_ADD, K_SUB, K_AND, K_OR: begin
        ex = sel_f(alu_op(k));
        mk = M_SIDE | M_SEL | M_SRC;
      end
      K_ADDI, K_ANDI, K_ORI, K_LW: begin
        ex = sel_f(alu_op(k)) | O_IMM | immsel_f(0);
        mk = M_SIDE | M_SEL | M_SRC | M_IMMSEL;
      end
      K_SW: begin
        ex = sel_f(0) | O_IMM | immsel_f(1);
        mk = M_SIDE | M_SEL | M_SRC | M_IMMSEL;
      end
      default: begin
        ex = sel_f(1) | immsel_f(2) | (zero ? (O_PCWE | O_BR) : 15'h0);
        mk = M_SIDE | M_SEL | M_SRC | M_IMMSEL;
      end
    endcase
    step("EXEC", rnd_bit(), zero, ex, mk);

    if (k == K_BEQ) return;
    if (k == K_LW || k == K_SW) begin
      ex = O_MREQ | O_ADDR | ((k == K_SW) ? O_MWE : 15'h0);
      mem_phase("MEM", wm, ex, ex, acked);
      if (!acked || k == K_SW) return;
    end
    step("WB", rnd_bit(), rnd_bit(), O_RWE | ((k == K_LW) ? O_WBM : 15'h0), M_SIDE | O_WBM);
  endtask

  function automatic int rnd_wait();
    if ($urandom_range(0, 15) == 0) return TO + int'($urandom_range(0, 3));
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    bus.ir       = 32'h0;
    bus.mem_ack  = 1'b1;
    bus.alu_zero = 1'b0;
    repeat (2) begin
      @(negedge clk);
      #1 check("RST_INIT", obs, 15'h0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    bus.mem_ack = 1'b0;

    run_instr(32'h002081B3, 0, 0, 1'b0);          // ADD, zero-wait
    run_instr(32'h402081B3, 1, 0, 1'b1);          // SUB
    run_instr(32'h0070F093, 0, 0, 1'b0);          // ANDI
    run_instr(32'h0070E093, 2, 0, 1'b0);          // ORI
    run_instr(32'h0040A283, 0, 3, 1'b0);          // LW, 3 waits in MEM
    run_instr(32'h0020A423, 0, 0, 1'b0);          // SW
    run_instr(32'h00208463, 0, 0, 1'b1);          // BEQ taken
    run_instr(32'h00208463, 0, 0, 1'b0);          // BEQ not taken
    run_instr(32'h002081B3, TO, 0, 1'b0);         // FETCH timeout then retry
    run_instr(32'h0040A283, 0, TO + 2, 1'b0);     // MEM timeout abandons LW
    run_instr(32'h0020A423, 1, TO, 1'b0);         // MEM timeout abandons SW
    run_instr(32'hFFFFFFFF, 0, 0, 1'b0);          // illegal
    run_instr(32'h002081B3, 0, 0, 1'b0);

    // Reset asserted while an LW waits in MEM.
    ir_cur = 32'h0040A283;
    step("R_FETCH", 1'b1, 1'b0, O_MREQ | O_IRWE | O_PCWE, M_SIDE);
    step("R_DECODE", 1'b0, 1'b0, 15'h0, M_SIDE);
    step("R_EXEC", 1'b0, 1'b0, O_IMM, M_SIDE | M_SEL | M_SRC | M_IMMSEL);
    step("R_MEM", 1'b0, 1'b0, O_MREQ | O_ADDR, M_SIDE);
    #2 rst = 1'b1;
    #1 check("RST_ASYNC", obs, 15'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_instr(32'h402081B3, 0, 0, 1'b0);          // first cycle after release: FETCH

    for (int n = 0; n < 300; n++) begin
      logic [31:0] w;
      if ($urandom_range(0, 9) == 0) w = $urandom;
      else w = make_ir(int'($urandom_range(0, 10)));
      run_instr(w, rnd_wait(), rnd_wait(), rnd_bit());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
